// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: drives one row low at a time, classifies each
// full scan frame, debounces presses/releases and keeps the last four keys.
module keypad_scanner_4x4 #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [3:0]  key,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] digits
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, RELEASE_DB} state_t;

    logic [3:0]    col_meta_reg, col_sync_reg;
    logic [DW-1:0] div_reg;
    logic [1:0]    row_idx_reg;
    logic [1:0]    hits_reg;
    logic [3:0]    code_reg;
    state_t        state_reg, state_next;
    logic [3:0]    count_reg, count_next;
    logic [3:0]    cand_reg, cand_next;
    logic [3:0]    key_reg;
    logic          key_valid_reg, key_held_reg;
    logic [15:0]   digits_reg;

    logic          slot_end, frame_end;
    logic [2:0]    row_hits;
    logic [1:0]    hit_col;
    logic [1:0]    hits_total;
    logic [3:0]    code_total;
    logic          accept, release_key;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;
            4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
            4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;
            4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
            4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;
            4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
            4'hC: key_code = 4'hE;  4'hD: key_code = 4'h0;
            4'hE: key_code = 4'hF;  default: key_code = 4'hD;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            assign row[gi] = (row_idx_reg != 2'(gi));
        end
    endgenerate

    assign key       = key_reg;
    assign key_valid = key_valid_reg;
    assign key_held  = key_held_reg;
    assign digits    = digits_reg;

    assign slot_end  = (div_reg == DW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (row_idx_reg == 2'd3);

    // Per-slot column hits merged into the running frame tally (saturates at 2 = MULTI).
    always_comb begin
        row_hits = 3'd0;
        hit_col  = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if (!col_sync_reg[c]) begin
                row_hits = row_hits + 3'd1;
                hit_col  = 2'(c);
            end
        end
        if (hits_reg == 2'd2 || row_hits >= 3'd2 || (hits_reg == 2'd1 && row_hits == 3'd1))
            hits_total = 2'd2;
        else
            hits_total = hits_reg + row_hits[1:0];
        code_total = (row_hits == 3'd1) ? key_code(row_idx_reg, hit_col) : code_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta_reg <= 4'hF;
            col_sync_reg <= 4'hF;
            div_reg      <= '0;
            row_idx_reg  <= 2'd0;
            hits_reg     <= 2'd0;
            code_reg     <= 4'h0;
        end else begin
            col_meta_reg <= col;
            col_sync_reg <= col_meta_reg;
            if (slot_end) begin
                div_reg     <= '0;
                row_idx_reg <= row_idx_reg + 2'd1;
                hits_reg    <= frame_end ? 2'd0 : hits_total;
                code_reg    <= frame_end ? 4'h0 : code_total;
            end else begin
                div_reg <= div_reg + DW'(1);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        cand_next   = cand_reg;
        accept      = 1'b0;
        release_key = 1'b0;
        if (frame_end) begin
            case (state_reg)
                IDLE: begin
                    if (hits_total == 2'd1) begin
                        cand_next  = code_total;
                        count_next = 4'd1;
                        if (DEBOUNCE == 1) begin
                            state_next = PRESSED;
                            accept     = 1'b1;
                        end else begin
                            state_next = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (hits_total == 2'd1) begin
                        if (code_total == cand_reg) begin
                            count_next = count_reg + 4'd1;
                            if (count_reg + 4'd1 == 4'(DEBOUNCE)) begin
                                state_next = PRESSED;
                                accept     = 1'b1;
                            end
                        end else begin
                            cand_next  = code_total;
                            count_next = 4'd1;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
                PRESSED: begin
                    if (hits_total == 2'd0) begin
                        count_next = 4'd1;
                        if (DEBOUNCE == 1) begin
                            state_next  = IDLE;
                            release_key = 1'b1;
                        end else begin
                            state_next = RELEASE_DB;
                        end
                    end
                end
                default: begin
                    if (hits_total == 2'd0) begin
                        count_next = count_reg + 4'd1;
                        if (count_reg + 4'd1 == 4'(DEBOUNCE)) begin
                            state_next  = IDLE;
                            release_key = 1'b1;
                        end
                    end else begin
                        state_next = PRESSED;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= 4'd0;
            cand_reg      <= 4'h0;
            key_reg       <= 4'h0;
            key_valid_reg <= 1'b0;
            key_held_reg  <= 1'b0;
            digits_reg    <= 16'h0000;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            cand_reg      <= cand_next;
            key_valid_reg <= accept;
            if (accept) begin
                key_reg      <= code_total;
                key_held_reg <= 1'b1;
                digits_reg   <= {digits_reg[11:0], code_total};
            end else if (release_key) begin
                key_held_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Directed bench for keypad_scanner_4x4 with a keypad model and a scoreboard of expected acceptances.
module tb_keypad_scanner_4x4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;
    logic [15:0] digits;

    logic [15:0] keys = 16'h0000;   // pressed switches, index row*4+col

    typedef struct {
        logic [3:0]  k;
        logic [15:0] d;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    keypad_scanner_4x4 #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk(clk), .rst(rst), .col(col), .row(row),
        .key(key), .key_valid(key_valid), .key_held(key_held), .digits(digits)
    );

    always #5 clk = ~clk;

    always_comb begin
        col = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every key_valid cycle must match the oldest expected acceptance.
    always @(negedge clk) begin
        if (!rst && key_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {28'd0, key}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("pulse_key", {28'd0, key}, {28'd0, e.k});
                check("pulse_digits", {16'd0, digits}, {16'd0, e.d});
                check("pulse_held", {31'd0, key_held}, 32'd1);
            end
            $display("pulse: key=%0h digits=%04h", key, digits);
        end
    end

    // Returns at the negedge of the first cycle of a new scan frame, n times.
    task automatic wait_frames(input int n);
        for (int i = 0; i < n; i++) begin
            logic [3:0] prev;
            int cyc;
            prev = row;
            cyc  = 0;
            forever begin
                @(negedge clk);
                if (prev == 4'b0111 && row == 4'b1110) break;
                prev = row;
                cyc++;
                if (cyc > 200) begin
                    check("frame_timeout", 32'(cyc), 32'd0);
                    break;
                end
            end
        end
    endtask

    task automatic push_exp(input logic [3:0] k, input logic [15:0] d);
        exp_t e;
        e.k = k;
        e.d = d;
        sb_q.push_back(e);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_row", {28'd0, row}, 32'hE);
        check("rst_key", {28'd0, key}, 32'd0);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_held", {31'd0, key_held}, 32'd0);
        check("rst_digits", {16'd0, digits}, 32'd0);
        rst = 1'b0;
        wait_frames(1);

        // Steady press of key 6 (row1/col2)
        keys[1*4+2] = 1'b1;
        push_exp(4'h6, 16'h0006);
        wait_frames(5);
        @(negedge clk);
        check("k6_key", {28'd0, key}, 32'h6);
        check("k6_held", {31'd0, key_held}, 32'd1);
        check("k6_digits", {16'd0, digits}, 32'h0006);
        check("k6_sb", 32'(sb_q.size()), 32'd0);

        // Release, then press key A (row0/col3)
        keys = 16'h0000;
        wait_frames(5);
        check("rel6_held", {31'd0, key_held}, 32'd0);
        check("rel6_key_kept", {28'd0, key}, 32'h6);
        keys[0*4+3] = 1'b1;
        push_exp(4'hA, 16'h006A);
        wait_frames(5);
        @(negedge clk);
        check("kA_key", {28'd0, key}, 32'hA);
        check("kA_digits", {16'd0, digits}, 32'h006A);
        keys = 16'h0000;
        wait_frames(5);
        check("relA_held", {31'd0, key_held}, 32'd0);

        // Bouncing contact on alternate frames
        for (int f = 0; f < 20; f++) begin
            keys[1*4+1] = (f % 2 == 0);
            wait_frames(1);
        end
        keys = 16'h0000;
        check("bounce_held", {31'd0, key_held}, 32'd0);
        wait_frames(3);

        // Keys 1 and 5 together, then release 5
        keys[0*4+0] = 1'b1;
        keys[1*4+1] = 1'b1;
        wait_frames(6);
        check("multi_held", {31'd0, key_held}, 32'd0);
        keys[1*4+1] = 1'b0;
        push_exp(4'h1, 16'h06A1);
        wait_frames(2);
        @(negedge clk);
        check("k1_not_yet", 32'(sb_q.size()), 32'd1);
        wait_frames(1);
        @(negedge clk);
        check("k1_after_3", 32'(sb_q.size()), 32'd0);
        keys = 16'h0000;
        wait_frames(5);

        // Key 0 held 100 frames, short 2-frame release, re-press
        keys[3*4+1] = 1'b1;
        push_exp(4'h0, 16'h6A10);
        wait_frames(100);
        check("k0_held", {31'd0, key_held}, 32'd1);
        keys = 16'h0000;
        wait_frames(2);
        keys[3*4+1] = 1'b1;
        wait_frames(5);
        check("k0_still_held", {31'd0, key_held}, 32'd1);
        check("k0_digits", {16'd0, digits}, 32'h6A10);

        // Reset while held; key stays pressed through reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_row", {28'd0, row}, 32'hE);
        check("mid_rst_key", {28'd0, key}, 32'd0);
        check("mid_rst_held", {31'd0, key_held}, 32'd0);
        check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
        check("mid_rst_digits", {16'd0, digits}, 32'd0);
        rst = 1'b0;
        push_exp(4'h0, 16'h0000);
        wait_frames(2);
        @(negedge clk);
        check("rst_k0_not_yet", 32'(sb_q.size()), 32'd1);
        wait_frames(1);
        @(negedge clk);
        check("rst_k0_after_3", 32'(sb_q.size()), 32'd0);
        check("rst_k0_held", {31'd0, key_held}, 32'd1);

        keys = 16'h0000;
        wait_frames(5);
        check("final_held", {31'd0, key_held}, 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
